// File: rtl/branch_resolve_unit_if.sv
// Bus bundle for the execute-stage branch resolution unit: decoded control-transfer
// inputs plus comparator flags in, resolved outcome, redirect, flush and counters out.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
);
  logic             valid_i;
  logic             stall_i;
  logic             is_branch;
  logic             is_jal;
  logic             is_jalr;
  logic [2:0]       funct3;
  logic             eq;
  logic             ls;
  logic             lu;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  rs1;
  logic             pred_taken;

  logic             taken_o;
  logic             redirect_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic [XLEN-1:0]  link_o;
  logic             flush_o;
  logic             misalign_o;
  logic             illegal_o;
  logic [CNT_W-1:0] br_count_o;
  logic [CNT_W-1:0] mp_count_o;

  modport master (
    output valid_i, stall_i, is_branch, is_jal, is_jalr, funct3, eq, ls, lu,
           pc, imm, rs1, pred_taken,
    input  taken_o, redirect_o, redirect_pc_o, link_o, flush_o, misalign_o,
           illegal_o, br_count_o, mp_count_o
  );

  modport slave (
    input  valid_i, stall_i, is_branch, is_jal, is_jalr, funct3, eq, ls, lu,
           pc, imm, rs1, pred_taken,
    output taken_o, redirect_o, redirect_pc_o, link_o, flush_o, misalign_o,
           illegal_o, br_count_o, mp_count_o
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps one cycle after acceptance, issues fetch redirects on
// mispredict, holds flush for FLUSH_CYCLES and keeps saturating perf counters.
module branch_resolve_unit #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic           clk,
  input  logic           rst,
  branch_resolve_unit_if.slave bus
);
  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e           state_q;
  logic [FCW-1:0]   fcnt_q;
  logic             taken_q;
  logic             redirect_q;
  logic [XLEN-1:0]  rpc_q;
  logic [XLEN-1:0]  link_q;
  logic             flush_q;
  logic             misalign_q;
  logic             illegal_q;
  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] mp_q;

  logic             accept;
  logic             taken_d;
  logic             illegal_d;
  logic             misalign_d;
  logic             redirect_d;
  logic [XLEN-1:0]  target_d;
  logic [XLEN-1:0]  link_d;
  logic [XLEN-1:0]  rpc_d;

  always_comb begin
    accept     = bus.valid_i & ~bus.stall_i & (state_q == IDLE) &
                 (bus.is_branch | bus.is_jal | bus.is_jalr);
    taken_d    = 1'b0;
    illegal_d  = 1'b0;
    target_d   = bus.pc + bus.imm;
    link_d     = bus.pc + XLEN'(4);
    if (bus.is_jalr) begin
      target_d = (bus.rs1 + bus.imm) & ~XLEN'(1);
      taken_d  = 1'b1;
    end else if (bus.is_jal) begin
      taken_d  = 1'b1;
    end else begin
      unique case (bus.funct3)
        3'b000:  taken_d = bus.eq;
        3'b001:  taken_d = ~bus.eq;
        3'b100:  taken_d = bus.ls;
        3'b101:  taken_d = ~bus.ls;
        3'b110:  taken_d = bus.lu;
        3'b111:  taken_d = ~bus.lu;
        default: illegal_d = 1'b1;
      endcase
    end
    // A misaligned taken target suppresses the redirect entirely.
    misalign_d = taken_d & target_d[1] & ~illegal_d;
    redirect_d = ~illegal_d & ~misalign_d & (bus.is_jalr | (taken_d != bus.pred_taken));
    rpc_d      = taken_d ? target_d : link_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fcnt_q     <= '0;
      taken_q    <= 1'b0;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
      link_q     <= '0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      br_q       <= '0;
      mp_q       <= '0;
    end else begin
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      if (state_q == FLUSH) begin
        if (fcnt_q == '0) begin
          state_q <= IDLE;
          flush_q <= 1'b0;
        end else begin
          fcnt_q  <= fcnt_q - FCW'(1);
        end
      end
      if (accept) begin
        taken_q    <= taken_d;
        link_q     <= link_d;
        illegal_q  <= illegal_d;
        misalign_q <= misalign_d;
        if (!illegal_d && br_q != '1) br_q <= br_q + CNT_W'(1);
        if (redirect_d) begin
          redirect_q <= 1'b1;
          rpc_q      <= rpc_d;
          flush_q    <= 1'b1;
          state_q    <= FLUSH;
          fcnt_q     <= FCW'(FLUSH_CYCLES - 1);
          if (mp_q != '1) mp_q <= mp_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.taken_o       = taken_q;
  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = rpc_q;
  assign bus.link_o        = link_q;
  assign bus.flush_o       = flush_q;
  assign bus.misalign_o    = misalign_q;
  assign bus.illegal_o     = illegal_q;
  assign bus.br_count_o    = br_q;
  assign bus.mp_count_o    = mp_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit against an operand-level model.
module tb_branch_resolve_unit;
  localparam int XLEN = 64;
  localparam int FC   = 2;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();
  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic        m_taken, m_redir, m_flush, m_mis, m_ill;
  logic [63:0] m_rpc, m_link;
  int          m_br, m_mp, m_left;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Model works on the operand values themselves rather than the comparator flags.
  task automatic model_step(input logic r, v, s, br, jal, jalr, input logic [2:0] f3,
                            input logic [63:0] a, b, pcv, immv, rs1v, input logic pt);
    logic        idle, tk, ill;
    logic [63:0] tgt;
    m_redir = 1'b0; m_mis = 1'b0; m_ill = 1'b0;
    if (r) begin
      m_taken = 1'b0; m_rpc = '0; m_link = '0; m_br = 0; m_mp = 0; m_left = 0;
    end else begin
      idle = (m_left == 0);
      if (m_left > 0) m_left--;
      if (v && !s && idle && (br || jal || jalr)) begin
        tk = 1'b0; ill = 1'b0; tgt = pcv + immv;
        if (jalr) begin
          tgt = (rs1v + immv) & ~64'd1; tk = 1'b1;
        end else if (jal) begin
          tk = 1'b1;
        end else begin
          case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) <  $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a <  b);
            3'd7: tk = (a >= b);
            default: ill = 1'b1;
          endcase
        end
        m_taken = tk;
        m_link  = pcv + 64'd4;
        if (ill) m_ill = 1'b1;
        else begin
          if (m_br < CMAX) m_br++;
          if (tk && tgt[1]) m_mis = 1'b1;
          else if (jalr || tk != pt) begin
            m_redir = 1'b1;
            m_rpc   = tk ? tgt : pcv + 64'd4;
            if (m_mp < CMAX) m_mp++;
            m_left  = FC;
          end
        end
      end
    end
    m_flush = (m_left > 0);
  endtask

  task automatic check_all();
    check("taken_o",       {63'd0, bus.taken_o},    {63'd0, m_taken});
    check("redirect_o",    {63'd0, bus.redirect_o}, {63'd0, m_redir});
    check("redirect_pc_o", bus.redirect_pc_o,       m_rpc);
    check("link_o",        bus.link_o,              m_link);
    check("flush_o",       {63'd0, bus.flush_o},    {63'd0, m_flush});
    check("misalign_o",    {63'd0, bus.misalign_o}, {63'd0, m_mis});
    check("illegal_o",     {63'd0, bus.illegal_o},  {63'd0, m_ill});
    check("br_count_o",    64'(bus.br_count_o),     64'(m_br));
    check("mp_count_o",    64'(bus.mp_count_o),     64'(m_mp));
  endtask

  task automatic drive(input logic r, v, s, br, jal, jalr, input logic [2:0] f3,
                       input logic [63:0] a, b, pcv, immv, rs1v, input logic pt);
    rst            = r;
    bus.valid_i    = v;
    bus.stall_i    = s;
    bus.is_branch  = br;
    bus.is_jal     = jal;
    bus.is_jalr    = jalr;
    bus.funct3     = f3;
    bus.eq         = (a == b);
    bus.ls         = ($signed(a) < $signed(b));
    bus.lu         = (a < b);
    bus.pc         = pcv;
    bus.imm        = immv;
    bus.rs1        = rs1v;
    bus.pred_taken = pt;
    model_step(r, v, s, br, jal, jalr, f3, a, b, pcv, immv, rs1v, pt);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_cyc();
    drive(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [63:0] vals [7];

  initial begin
    vals[0] = 64'd0; vals[1] = 64'd1; vals[2] = 64'd2; vals[3] = '1;
    vals[4] = 64'hFFFF_FFFF_FFFF_FFFE; vals[5] = 64'h8000_0000_0000_0000;
    vals[6] = 64'h7FFF_FFFF_FFFF_FFFF;

    reset_cyc(); reset_cyc();
    check("reset_flush", {63'd0, bus.flush_o}, 64'd0);

    // BEQ taken, predicted not-taken
    drive(0, 1, 0, 1, 0, 0, 3'd0, 5, 5, 64'h1000, 64'h40, 0, 0);
    check("beq_rpc", bus.redirect_pc_o, 64'h1040);
    check("beq_mp", 64'(bus.mp_count_o), 64'd1);
    idle_cyc(1);
    check("beq_flush2", {63'd0, bus.flush_o}, 64'd1);
    idle_cyc(1);
    check("beq_flush_end", {63'd0, bus.flush_o}, 64'd0);

    // BLTU not taken, predicted taken -> fall-through redirect
    drive(0, 1, 0, 1, 0, 0, 3'd6, 5, 3, 64'h2000, 64'h80, 0, 1);
    check("bltu_rpc", bus.redirect_pc_o, 64'h2004);
    idle_cyc(2);
    // BGE taken, correctly predicted
    drive(0, 1, 0, 1, 0, 0, 3'd5, 5, 3, 64'h2100, 64'h10, 0, 1);
    check("bge_noredir", {63'd0, bus.redirect_o}, 64'd0);

    // JALR clears bit 0 of target
    drive(0, 1, 0, 0, 0, 1, 3'd0, 0, 0, 64'h4000, 64'h5, 64'h3003, 1);
    check("jalr_rpc", bus.redirect_pc_o, 64'h3008);
    check("jalr_link", bus.link_o, 64'h4004);
    idle_cyc(2);
    drive(0, 1, 0, 0, 1, 0, 3'd0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 0, 0);
    check("jal_wrap", bus.redirect_pc_o, 64'h10);
    idle_cyc(2);

    // Illegal funct3, then misaligned JAL target
    drive(0, 1, 0, 1, 0, 0, 3'd2, 0, 0, 64'h500, 64'h8, 0, 0);
    check("illegal_pulse", {63'd0, bus.illegal_o}, 64'd1);
    drive(0, 1, 0, 0, 1, 0, 3'd0, 0, 0, 64'h1000, 64'h2, 0, 1);
    check("misalign_pulse", {63'd0, bus.misalign_o}, 64'd1);
    idle_cyc(1);

    // Redirect, two squashed valids, third accepted
    drive(0, 1, 0, 1, 0, 0, 3'd1, 1, 2, 64'h600, 64'h20, 0, 0);
    drive(0, 1, 0, 0, 1, 0, 3'd0, 0, 0, 64'h700, 64'h8, 0, 0);
    drive(0, 1, 0, 0, 1, 0, 3'd0, 0, 0, 64'h800, 64'h8, 0, 0);
    drive(0, 1, 0, 0, 1, 0, 3'd0, 0, 0, 64'h900, 64'h8, 0, 1);
    check("third_link", bus.link_o, 64'h904);

    // Reset during flush with valid_i asserted
    drive(0, 1, 0, 0, 1, 0, 3'd0, 0, 0, 64'hA00, 64'h8, 0, 0);
    drive(1, 1, 0, 0, 1, 0, 3'd0, 0, 0, 64'hB00, 64'h8, 0, 0);
    check("rst_in_flush", {63'd0, bus.flush_o}, 64'd0);

    // Counter saturation
    for (int i = 0; i < CMAX + 6; i++)
      drive(0, 1, 0, 0, 1, 0, 3'd0, 0, 0, 64'h0, 64'h8, 0, 1);
    check("br_sat", 64'(bus.br_count_o), 64'(CMAX));
    for (int i = 0; i < CMAX + 6; i++) begin
      drive(0, 1, 0, 0, 1, 0, 3'd0, 0, 0, 64'h0, 64'h8, 0, 0);
      idle_cyc(FC);
    end
    check("mp_sat", 64'(bus.mp_count_o), 64'(CMAX));

    reset_cyc();
    for (int i = 0; i < 1500; i++) begin
      logic [63:0] pcv, immv;
      pcv  = {$urandom, $urandom} & ~64'd3;
      if ($urandom_range(0, 7) == 0) pcv = pcv | 64'd2;
      immv = 64'($signed($urandom_range(0, 4095)) - 2048) & ~64'd1;
      if ($urandom_range(0, 3) != 0) immv = immv & ~64'd3;
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
            1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            3'($urandom), vals[$urandom_range(0, 6)], vals[$urandom_range(0, 6)],
            pcv, immv, {$urandom, $urandom}, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage branch resolution block directly downstream of the 64-bit comparator. It consumes the comparator's eq/ls/lu flags plus the decoded control-transfer info.
- Decides branch/jump outcome and computes the target, with one registered cycle of latency.
- Raises a redirect to fetch on mispredict and drives a multi-cycle pipeline flush through a small FSM.
- Keeps saturating branch/mispredict performance counters.

Parameters:
- XLEN, 64, datapath width of pc/imm/rs1/targets
- FLUSH_CYCLES, 2, number of cycles flush_o is held after a redirect (≥1)
- CNT_W, 32, width of the performance counters

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- valid_i  input  1  a control-transfer instruction is presented this cycle
- stall_i  input  1  pipeline stall; input is not accepted while high
- is_branch  input  1  conditional branch (B-type)
- is_jal  input  1  JAL
- is_jalr  input  1  JALR
- funct3  input  3  branch condition selector
- eq  input  1  comparator: rs1 == rs2
- ls  input  1  comparator: rs1 < rs2, signed
- lu  input  1  comparator: rs1 < rs2, unsigned
- pc  input  XLEN  instruction address
- imm  input  XLEN  sign-extended immediate
- rs1  input  XLEN  rs1 value (JALR base)
- pred_taken  input  1  fetch-stage prediction
- taken_o  output  1  resolved outcome, registered
- redirect_o  output  1  one-cycle pulse: fetch must restart at redirect_pc_o
- redirect_pc_o  output  XLEN  corrected fetch address
- link_o  output  XLEN  pc+4 for JAL/JALR writeback
- flush_o  output  1  squash younger instructions
- misalign_o  output  1  one-cycle pulse: taken target not 4-byte aligned
- illegal_o  output  1  one-cycle pulse: branch with funct3 010/011
- br_count_o  output  CNT_W  resolved control transfers
- mp_count_o  output  CNT_W  redirects issued

Behaviour:
- Reset (synchronous, highest priority over all events): all outputs 0, FSM to IDLE, counters 0.
- Accept condition: valid_i & ~stall_i & state==IDLE. Results appear on registered outputs the following cycle (latency 1).
- Condition decode (is_branch):
  - 000 BEQ: eq
  - 001 BNE: ~eq
  - 100 BLT: ls
  - 101 BGE: ~ls
  - 110 BLTU: lu
  - 111 BGEU: ~lu
  - 010/011: taken=0, illegal_o pulses, no redirect, no count.
- is_jal and is_jalr are always taken. Target priority is is_jalr > is_jal > is_branch. If none of the three is set, the accept is treated as a no-op.
- Target arithmetic, modulo 2^XLEN (wrap-around, no overflow detection):
  - branch/JAL: pc+imm
  - JALR: (rs1+imm) & ~1
  - link_o = pc+4 for all accepted instructions
- Alignment: if taken and target[1]≠0, misalign_o pulses, with no redirect and no flush; counted in br_count_o only.
- Redirect rules:
  - Branch/JAL: redirect when taken≠pred_taken. redirect_pc_o = taken ? target : pc+4.
  - JALR: always redirect to target.
- Outputs without redirect: redirect_o=0 and redirect_pc_o holds its previous value. taken_o holds until the next accept.
- Pulse width: redirect_o, misalign_o and illegal_o are exactly one cycle wide, even if stall_i rises.
- FSM IDLE→FLUSH:
  - Trigger: the cycle redirect_o is asserted.
  - flush_o is high from that cycle for exactly FLUSH_CYCLES cycles, driven by a down-counter.
  - FLUSH→IDLE when the counter reaches 0.
  - In FLUSH, valid_i is ignored: squashed, with no outputs changed and no counting. stall_i does not extend the flush.
- Counters:
  - br_count_o increments on each accept except illegal.
  - mp_count_o increments on each redirect.
  - Both saturate at all-ones and do not wrap.

Test Plan:
- BEQ, eq=1, pc=0x1000, imm=0x40, pred_taken=0 → next cycle taken_o=1, redirect_o=1, redirect_pc_o=0x1040, flush_o high 2 cycles, mp_count_o=1.
- BLTU, lu=0, pred_taken=1, pc=0x2000 → redirect_pc_o=0x2004, taken_o=0. Also BGE with ls=0 and pred_taken=1 → no redirect, flush_o stays 0.
- JALR, rs1=0x3003, imm=0x5 → redirect_pc_o=0x3008, link_o=pc+4. JAL with pc=0xFFFF_FFFF_FFFF_FFF0, imm=0x20 → target 0x10 (wrap).
- funct3=010 → illegal_o single pulse, no redirect, br_count_o unchanged. JAL target 0x1002 → misalign_o pulse, no flush.
- Redirect followed by valid_i on each of the next 2 cycles → both squashed, counters unchanged. Third valid_i is accepted.
- rst asserted in FLUSH together with valid_i → next cycle all outputs 0, state IDLE. Preload counter near max → saturates at 0xFFFF_FFFF.
